ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative multiply/divide execution unit with architectural HI/LO registers. It sits in the EX stage and consumes the decoded function code and operands delivered by the ID/EX pipeline register. It executes MULT/MULTU/DIV/DIVU over multiple cycles and serves MFHI/MFLO/MTHI/MTLO. While an operation is in flight it raises a stall so the ID/EX register and earlier stages hold.

## Interface

Parameters:
- none; the datapath width is fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- valid_in  input  1  the ID/EX register holds a valid instruction this cycle
- funct_in  input  6  R-type funct field from ID/EX
- operand_1_in  input  32  rs value (multiplicand / dividend / MTHI-MTLO source)
- operand_2_in  input  32  rt value (multiplier / divisor)
- stall_out  output  1  combinational; hold upstream pipeline, instruction not accepted
- busy_out  output  1  registered; iterative operation in progress
- done_out  output  1  registered; one-cycle pulse, HI/LO just updated by MULT/DIV
- hi_out  output  32  HI register
- lo_out  output  32  LO register
- mf_data_out  output  32  combinational; HI for MFHI, LO for MFLO, 0 otherwise

## Operation

- Recognised funct values: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other funct, or valid_in=0, means no action and stall_out=0.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE → MUL on an accepted MULT/MULTU.
  - IDLE → DIV on an accepted DIV/DIVU.
  - MUL/DIV → FIX after 32 iterations.
  - FIX → IDLE unconditionally.
- An instruction is accepted when it is recognised, valid_in=1, and state==IDLE.
- stall_out = valid_in & recognised & (state != IDLE). This covers MF/MT instructions as well as a new MULT/DIV.
- On accept, the unit latches operand magnitudes, the sign flags, the signed/unsigned mode, and the op type. It clears a 6-bit iteration counter.
- Signed ops (MULT/DIV) use two's-complement absolute values; unsigned ops use the raw operands.
- MUL: radix-2 shift-add over a 64-bit accumulator, one bit per cycle.
- DIV: restoring division, one quotient bit per cycle, 33-bit partial remainder.
- FIX applies sign correction and writes HI/LO:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero (operand_2_in==0, either signedness): LO=0xFFFFFFFF, HI=operand_1_in unmodified. Latency is identical to a normal divide.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: when accepted, HI/LO takes operand_1_in on that edge. No FSM change and no done pulse.
- MFHI/MFLO: when accepted, mf_data_out returns the current register value in the same cycle.

## Timing

- Reset (rst=1 at an edge): state=IDLE, HI=0, LO=0, counter=0, busy_out=0, done_out=0. An in-flight operation is aborted with no partial HI/LO write.
- Let E0 be the accept edge.
  - MUL/DIV iterate on edges E1–E32.
  - FIX writes HI/LO on edge E33.
  - busy_out is 1 from after E0 until after E33, i.e. 33 cycles.
  - done_out is 1 for exactly the cycle after E33.
- Result latency is 33 cycles: an MFLO presented in the cycle following E33 reads the new value.
- A new instruction may be accepted in the done_out cycle, because state is already IDLE.
- While busy, hi_out/lo_out keep their previous values.
- MTHI/MTLO take effect at the accept edge. MFHI/MFLO are combinational in the accept cycle.
- If rst and valid_in are both high, reset wins and the instruction is not accepted.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after E33: HI=0xFFFFFFFE, LO=0x00000001; done_out high for one cycle; busy_out high for 33 cycles.
- MULT −3 (0xFFFFFFFD) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 → LO=0xFFFFFFFF, HI=0x12345678 after 33 cycles.
- Issue MFLO at E0+5 during a MULT → stall_out=1 until state returns to IDLE. Then mf_data_out equals the new LO, and MTHI 0xA5A5A5A5 takes effect on the next accept edge.
- Assert rst at E0+10 of a DIV with HI/LO preloaded via MTHI/MTLO → next cycle HI=LO=0, busy_out=0, no done_out pulse.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Iterative multiply/divide unit for the EX stage, owning the architectural
// HI/LO registers. MULT/MULTU use radix-2 shift-add and DIV/DIVU use
// restoring division, one bit per cycle for 32 cycles. One FIX cycle then
// applies sign correction and writes HI/LO. MTHI/MTLO write on their accept
// edge. MFHI/MFLO are answered combinationally in their accept cycle.
//
// Handshake: an instruction is taken on a rising edge when valid_in=1, funct
// is recognised and the unit is idle. Otherwise a recognised instruction sees
// stall_out=1 and must be held unchanged by the ID/EX register.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset (aborts any operation)
//   valid_in      ID/EX holds a valid instruction
//   funct_in      R-type funct field
//   operand_1_in  rs: multiplicand / dividend / MTHI-MTLO source
//   operand_2_in  rt: multiplier / divisor
//   stall_out     combinational, recognised instruction not accepted
//   busy_out      registered, iterative operation in progress
//   done_out      registered, one-cycle pulse after HI/LO written by FIX
//   hi_out        HI register
//   lo_out        LO register
//   mf_data_out   combinational, HI for MFHI / LO for MFLO when accepted
// ---------------------------------------------------------------------------
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [5:0]  funct_in,
    input  logic [31:0] operand_1_in,
    input  logic [31:0] operand_2_in,
    output logic        stall_out,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] mf_data_out
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      r_state;
    logic [63:0] r_acc;       // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [31:0] r_opb;       // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic        r_sign_a;    // operand_1 negative (signed ops only)
    logic        r_sign_b;    // operand_2 negative (signed ops only)
    logic        r_is_div;
    logic        r_div_zero;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_recognised;
    logic        w_idle;
    logic        w_accept;
    logic        w_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_rem_shift;
    logic        w_div_ge;
    logic [31:0] w_div_sub;
    logic [63:0] w_div_next;
    logic [63:0] w_prod_neg;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    always_comb begin
        w_recognised = 1'b0;
        case (funct_in)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: w_recognised = 1'b1;
            default:                        w_recognised = 1'b0;
        endcase
    end

    assign w_idle    = (r_state == S_IDLE);
    assign w_accept  = valid_in & w_recognised & w_idle;
    assign stall_out = valid_in & w_recognised & ~w_idle;

    // Signed variants have funct bit 0 clear (MULT 0x18, DIV 0x1A).
    assign w_signed = ~funct_in[0];
    assign w_mag_a  = (w_signed & operand_1_in[31]) ? (32'd0 - operand_1_in) : operand_1_in;
    assign w_mag_b  = (w_signed & operand_2_in[31]) ? (32'd0 - operand_2_in) : operand_2_in;

    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole 65-bit result right.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Restoring step: bring in the next dividend bit; subtract the divisor
    // when it fits. When it fits the difference is below the divisor, so
    // 32 bits hold it; when it does not, the shifted value is below 2^32.
    assign w_rem_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_ge    = (w_rem_shift >= {1'b0, r_opb});
    assign w_div_sub   = w_rem_shift[31:0] - r_opb;
    assign w_div_next  = w_div_ge ? {w_div_sub, r_acc[30:0], 1'b1}
                                  : {w_rem_shift[31:0], r_acc[30:0], 1'b0};

    assign w_prod_neg = 64'd0 - r_acc;

    // Sign correction. For a zero divisor the remainder equals |dividend|,
    // so restoring the dividend's sign reproduces operand_1 exactly.
    always_comb begin
        w_fix_hi = r_acc[63:32];
        w_fix_lo = r_acc[31:0];
        if (r_is_div) begin
            w_fix_hi = r_sign_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
            if (r_div_zero)
                w_fix_lo = 32'hFFFF_FFFF;
            else if (r_sign_a ^ r_sign_b)
                w_fix_lo = 32'd0 - r_acc[31:0];
            else
                w_fix_lo = r_acc[31:0];
        end else if (r_sign_a ^ r_sign_b) begin
            w_fix_hi = w_prod_neg[63:32];
            w_fix_lo = w_prod_neg[31:0];
        end
    end

    always_comb begin
        mf_data_out = 32'd0;
        if (valid_in && w_idle) begin
            if (funct_in == F_MFHI)
                mf_data_out = r_hi;
            else if (funct_in == F_MFLO)
                mf_data_out = r_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= 64'd0;
            r_opb      <= 32'd0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= 6'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (funct_in)
                            F_MTHI: r_hi <= operand_1_in;
                            F_MTLO: r_lo <= operand_1_in;
                            F_MULT, F_MULTU: begin
                                r_state    <= S_MUL;
                                r_acc      <= {32'd0, w_mag_b};
                                r_opb      <= w_mag_a;
                                r_sign_a   <= w_signed & operand_1_in[31];
                                r_sign_b   <= w_signed & operand_2_in[31];
                                r_is_div   <= 1'b0;
                                r_div_zero <= 1'b0;
                                r_cnt      <= 6'd0;
                                r_busy     <= 1'b1;
                            end
                            F_DIV, F_DIVU: begin
                                r_state    <= S_DIV;
                                r_acc      <= {32'd0, w_mag_a};
                                r_opb      <= w_mag_b;
                                r_sign_a   <= w_signed & operand_1_in[31];
                                r_sign_b   <= w_signed & operand_2_in[31];
                                r_is_div   <= 1'b1;
                                r_div_zero <= (operand_2_in == 32'd0);
                                r_cnt      <= 6'd0;
                                r_busy     <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31)
                        r_state <= S_FIX;
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_out = r_busy;
    assign done_out = r_done;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Directed bench for ex_muldiv_unit. Each MULT/DIV pushes its hand-computed
// {HI,LO} into exp_q; a monitor pops an entry on every done_out pulse and
// compares HI, LO and the number of busy cycles. MF/MT, stall and reset
// behaviour are checked inline by the driver.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [5:0]  funct_in;
    logic [31:0] operand_1_in;
    logic [31:0] operand_2_in;
    logic        stall_out;
    logic        busy_out;
    logic        done_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mf_data_out;

    logic [63:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    int          busy_cnt;

    ex_muldiv_unit dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .funct_in     (funct_in),
        .operand_1_in (operand_1_in),
        .operand_2_in (operand_2_in),
        .stall_out    (stall_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .mf_data_out  (mf_data_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (busy_out === 1'b1) begin
            busy_cnt++;
        end else if (done_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_unexpected: actual done pulse hi=%h lo=%h, required no pulse", hi_out, lo_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_hi", hi_out, e[63:32]);
                check("sb_lo", lo_out, e[31:0]);
                check("sb_busy_cycles", busy_cnt, 32'd33);
            end
            busy_cnt = 0;
        end else begin
            busy_cnt = 0;
        end
    end

    // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid_in     = 1'b1;
        funct_in     = f;
        operand_1_in = a;
        operand_2_in = b;
        #1;
        check("stall_on_accept", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        funct_in = 6'h00;
        @(negedge clk);
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        exp_q.push_back({exp_hi, exp_lo});
        issue(f, a, b);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done_out !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (done_out !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: actual no done within 60 cycles, required done", name);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int done_count;
        n_checks     = 0;
        n_fail       = 0;
        busy_cnt     = 0;
        rst          = 1'b1;
        valid_in     = 1'b0;
        funct_in     = 6'h00;
        operand_1_in = 32'd0;
        operand_2_in = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);
        check("reset_busy", {31'd0, busy_out}, 32'd0);
        check("reset_done", {31'd0, done_out}, 32'd0);
        check("reset_stall", {31'd0, stall_out}, 32'd0);

        // MULTU max * max, then done must be a single-cycle pulse
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_done("multu_max");
        @(negedge clk);
        check("done_one_cycle", {31'd0, done_out}, 32'd0);
        check("busy_after_done", {31'd0, busy_out}, 32'd0);

        // Back-to-back: each new op is issued in the previous done cycle
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        wait_done("mult_neg");
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div_neg");
        run_op(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_done("divu_100_7");
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        wait_done("div_ovf");
        run_op(F_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        wait_done("divu_zero");
        run_op(F_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        wait_done("div_zero_neg");
        run_op(F_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        wait_done("div_pos_neg");
        @(negedge clk);

        // MFLO issued mid-MULT stalls until the unit is idle again
        run_op(F_MULT, 32'd5, 32'd6, 32'd0, 32'd30);
        repeat (4) @(negedge clk);
        valid_in = 1'b1;
        funct_in = F_MFLO;
        k = 0;
        #1;
        while (done_out !== 1'b1 && k < 60) begin
            check("stall_while_busy", {31'd0, stall_out}, 32'd1);
            @(negedge clk);
            #1;
            k++;
        end
        check("mflo_done_seen", {31'd0, done_out}, 32'd1);
        check("stall_released", {31'd0, stall_out}, 32'd0);
        check("mflo_new_lo", mf_data_out, 32'd30);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        funct_in = 6'h00;
        @(negedge clk);

        // MTHI takes effect on its accept edge, MFHI reads it combinationally
        valid_in     = 1'b1;
        funct_in     = F_MTHI;
        operand_1_in = 32'hA5A5_A5A5;
        #1;
        check("mthi_no_stall", {31'd0, stall_out}, 32'd0);
        check("mthi_before_edge", hi_out, 32'd0);
        @(posedge clk);
        #1;
        check("mthi_after_edge", hi_out, 32'hA5A5_A5A5);
        funct_in = F_MFHI;
        #1;
        check("mfhi_read", mf_data_out, 32'hA5A5_A5A5);
        valid_in = 1'b0;
        funct_in = 6'h00;
        @(negedge clk);

        // Preload HI/LO, start a DIV, reset mid-flight with a competing MTLO
        issue(F_MTHI, 32'h1111_1111, 32'd0);
        issue(F_MTLO, 32'h2222_2222, 32'd0);
        check("preload_hi", hi_out, 32'h1111_1111);
        check("preload_lo", lo_out, 32'h2222_2222);
        issue(F_DIV, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        check("busy_before_abort", {31'd0, busy_out}, 32'd1);
        rst          = 1'b1;
        valid_in     = 1'b1;
        funct_in     = F_MTLO;
        operand_1_in = 32'h3333_3333;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        funct_in = 6'h00;
        @(negedge clk);
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        check("abort_busy", {31'd0, busy_out}, 32'd0);
        check("abort_done", {31'd0, done_out}, 32'd0);
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_out === 1'b1) done_count++;
        end
        check("abort_no_done", done_count, 32'd0);

        // Unit is usable again after the abort
        run_op(F_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
        wait_done("multu_after_abort");
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
